// File: rtl/vector_cache_pkg.sv
// Shared vector-cache MSHR constants and types.
package vector_cache_pkg;

   localparam int MSHR_ENTRY_NUM = 16;
   localparam int MSHR_IDX_WIDTH = $clog2(MSHR_ENTRY_NUM);

   typedef logic [MSHR_IDX_WIDTH-1:0] mshr_idx_t;

endpackage

// File: rtl/vec_cache_first2_sel.sv
// Combinational find-first-two-set-bits: lowest and second-lowest set bit as
// one-hot vectors, binary indices and valids (index is 0 when not valid).
module vec_cache_first2_sel #(
   parameter int N = 16,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [N-1:0] oh_0,
   output logic [N-1:0] oh_1,
   output logic [W-1:0] idx_0,
   output logic [W-1:0] idx_1,
   output logic         vld_0,
   output logic         vld_1
);

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0] rest_s;

   // Isolate lowest set bit twice, then encode the one-hot results.
   always_comb begin
      oh_0   = vec & (~vec + ONE);
      rest_s = vec & ~oh_0;
      oh_1   = rest_s & (~rest_s + ONE);
      vld_0  = |vec;
      vld_1  = |rest_s;
      idx_0  = '0;
      idx_1  = '0;
      for (int i = 0; i < N; i++) begin
         idx_0 = idx_0 | ({W{oh_0[i]}} & W'(i));
         idx_1 = idx_1 | ({W{oh_1[i]}} & W'(i));
      end
   end

endmodule

// File: rtl/vec_cache_mshr_alloc_chk.sv
// Double-free checker for the MSHR allocator, built only with VEC_CACHE_MSHR_ALLOC_CHK_EN.
`ifdef VEC_CACHE_MSHR_ALLOC_CHK_EN
module vec_cache_mshr_alloc_chk (
   input logic clk,
   input logic rst_n,
   input logic dbl_free
);

   a_no_double_free: assert property (@(posedge clk) disable iff (!rst_n) !dbl_free)
      else $warning("vec_cache_mshr_alloc: double-free release observed");

endmodule
`endif

// File: rtl/vec_cache_mshr_alloc.sv
// MSHR/ROB free-list allocator offering two lowest free entries per cycle.
// Optional double-free detection is enabled by defining VEC_CACHE_MSHR_ALLOC_CHK_EN.
module vec_cache_mshr_alloc
   import vector_cache_pkg::*;
#(
   parameter  int ENTRY_NUM       = MSHR_ENTRY_NUM,
   parameter  int ENTRY_IDX_WIDTH = MSHR_IDX_WIDTH,
   parameter  int REL_NUM         = 2,
   localparam int CNT_WIDTH       = $clog2(ENTRY_NUM + 1)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   output logic                               mshr_alloc_vld_0,
   output logic [ENTRY_IDX_WIDTH-1:0]         mshr_alloc_idx_0,
   input  logic                               mshr_alloc_rdy_0,
   output logic                               mshr_alloc_vld_1,
   output logic [ENTRY_IDX_WIDTH-1:0]         mshr_alloc_idx_1,
   input  logic                               mshr_alloc_rdy_1,
   input  logic [REL_NUM-1:0]                 rel_vld,
   input  logic [REL_NUM*ENTRY_IDX_WIDTH-1:0] rel_idx,
   output logic [CNT_WIDTH-1:0]               free_cnt,
   output logic                               full,
   output logic                               err_double_free
);

   localparam logic [ENTRY_NUM-1:0] ONE_HOT0 = {{(ENTRY_NUM-1){1'b0}}, 1'b1};

   logic [ENTRY_NUM-1:0] busy_r;
   logic [ENTRY_NUM-1:0] busy_next_s;
   logic [ENTRY_NUM-1:0] oh_0_s;
   logic [ENTRY_NUM-1:0] oh_1_s;
   logic [ENTRY_NUM-1:0] alloc_mask_s;
   logic [ENTRY_NUM-1:0] rel_mask_s;
   logic [ENTRY_NUM-1:0] rel_eff_s;
   logic                 vld_0_s;
   logic                 vld_1_s;
   logic                 take_0_s;
   logic                 take_1_s;
   logic [CNT_WIDTH-1:0] free_cnt_r;
   logic [CNT_WIDTH-1:0] free_cnt_next_s;
   logic [CNT_WIDTH-1:0] rel_cnt_s;
   logic                 full_r;

   vec_cache_first2_sel #(
      .N (ENTRY_NUM),
      .W (ENTRY_IDX_WIDTH)
   ) u_sel (
      .vec   (~busy_r),
      .oh_0  (oh_0_s),
      .oh_1  (oh_1_s),
      .idx_0 (mshr_alloc_idx_0),
      .idx_1 (mshr_alloc_idx_1),
      .vld_0 (vld_0_s),
      .vld_1 (vld_1_s)
   );

   assign mshr_alloc_vld_0 = vld_0_s;
   assign mshr_alloc_vld_1 = vld_1_s;
   assign free_cnt         = free_cnt_r;
   assign full             = full_r;

   // Merge grants and releases; only releases of busy entries count, so an
   // index named on several ports is freed once.
   always_comb begin
      take_0_s     = vld_0_s & mshr_alloc_rdy_0;
      take_1_s     = vld_1_s & mshr_alloc_rdy_1;
      alloc_mask_s = (oh_0_s & {ENTRY_NUM{take_0_s}}) | (oh_1_s & {ENTRY_NUM{take_1_s}});
      rel_mask_s   = '0;
      for (int i = 0; i < REL_NUM; i++) begin
         rel_mask_s = rel_mask_s | ({ENTRY_NUM{rel_vld[i]}} &
                      (ONE_HOT0 << rel_idx[i*ENTRY_IDX_WIDTH +: ENTRY_IDX_WIDTH]));
      end
      rel_eff_s = rel_mask_s & busy_r;
      rel_cnt_s = '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
         rel_cnt_s = rel_cnt_s + CNT_WIDTH'(rel_eff_s[i]);
      end
      busy_next_s     = (busy_r & ~rel_eff_s) | alloc_mask_s;
      free_cnt_next_s = free_cnt_r + rel_cnt_s - CNT_WIDTH'(take_0_s) - CNT_WIDTH'(take_1_s);
   end

   // Occupancy state and registered status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r     <= '0;
         free_cnt_r <= CNT_WIDTH'(ENTRY_NUM);
         full_r     <= 1'b0;
      end else begin
         busy_r     <= busy_next_s;
         free_cnt_r <= free_cnt_next_s;
         full_r     <= (free_cnt_next_s == '0);
      end
   end

`ifdef VEC_CACHE_MSHR_ALLOC_CHK_EN
   logic dbl_free_s;
   logic err_r;

   // Flag releases of free entries and duplicate indices across ports.
   always_comb begin
      dbl_free_s = 1'b0;
      for (int i = 0; i < REL_NUM; i++) begin
         dbl_free_s = dbl_free_s |
                      (rel_vld[i] & ~busy_r[rel_idx[i*ENTRY_IDX_WIDTH +: ENTRY_IDX_WIDTH]]);
         for (int j = i + 1; j < REL_NUM; j++) begin
            dbl_free_s = dbl_free_s | (rel_vld[i] & rel_vld[j] &
                         (rel_idx[i*ENTRY_IDX_WIDTH +: ENTRY_IDX_WIDTH] ==
                          rel_idx[j*ENTRY_IDX_WIDTH +: ENTRY_IDX_WIDTH]));
         end
      end
   end

   // Sticky error until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r | dbl_free_s;
      end
   end

   assign err_double_free = err_r;

   vec_cache_mshr_alloc_chk u_chk (
      .clk      (clk),
      .rst_n    (rst_n),
      .dbl_free (dbl_free_s)
   );
`else
   assign err_double_free = 1'b0;
`endif

endmodule

// File: doc/vec_cache_mshr_alloc.md
Name: vec_cache_mshr_alloc

Overview:
Free-list allocator for MSHR/ROB entries. It sits directly upstream of the 8-to-2 request arbiter.
- Each cycle it offers up to two distinct free entry indices (alloc slot 0 and slot 1).
- Entries are marked busy when the arbiter consumes a slot; they are returned through release ports when the MSHR retires a transaction.
- It also provides occupancy status and error detection.

Parameters:
- ENTRY_NUM, 16, number of MSHR/ROB entries; power of two, ≥2.
- ENTRY_IDX_WIDTH, 4, width of an entry index; equals $clog2(ENTRY_NUM).
- REL_NUM, 2, number of independent release ports.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mshr_alloc_vld_0  out  1  slot 0 offers a free entry
- mshr_alloc_idx_0  out  ENTRY_IDX_WIDTH  slot 0 entry index
- mshr_alloc_rdy_0  in  1  slot 0 consumed this cycle
- mshr_alloc_vld_1  out  1  slot 1 offers a second, distinct free entry
- mshr_alloc_idx_1  out  ENTRY_IDX_WIDTH  slot 1 entry index
- mshr_alloc_rdy_1  in  1  slot 1 consumed this cycle
- rel_vld  in  REL_NUM  per-port release strobe
- rel_idx  in  REL_NUM*ENTRY_IDX_WIDTH  packed release indices; port i occupies bits [i*W +: W]
- free_cnt  out  $clog2(ENTRY_NUM+1)  number of free entries (registered)
- full  out  1  no free entry (free_cnt==0)
- err_double_free  out  1  sticky error flag (see Optional Feature)

Behaviour:
- State is a registered bitmap busy[ENTRY_NUM-1:0]. On reset: busy=0, free_cnt=ENTRY_NUM, full=0, err_double_free=0.
- Slot selection is combinational from the registered busy:
  - idx_0 = lowest free index; vld_0 = (free_cnt≥1).
  - idx_1 = second-lowest free index; vld_1 = (free_cnt≥2).
  - When a slot's vld is 0, its idx is 0.
- Handshake: the slot k entry is allocated when vld_k && rdy_k. rdy_k without vld_k is ignored.
  - Slots are independent: slot 1 may be taken without slot 0 in the same cycle.
  - vld/idx must not depend on rdy (no combinational loop).
- Allocated entries set busy on the next clock edge. Allocation latency is 1 cycle: an entry allocated in cycle N is never offered in cycle N+1.
- Release: rel_vld[i] clears busy[rel_idx[i]] at the next edge.
  - No same-cycle bypass: a released entry can first be offered in the cycle after release.
  - Two release ports naming the same index in one cycle count as a single release and a double-free error.
- Simultaneous alloc and release in one cycle are both applied. free_cnt_next = free_cnt − allocs + distinct valid releases of busy entries. free_cnt is kept consistent with popcount(~busy) at all times.
- Releasing an entry that is already free leaves busy unchanged and does not increment free_cnt.
- Boundaries:
  - With one free entry, only slot 0 is valid.
  - With zero free entries, full=1 and both vld are 0.
  - Releasing into a full pool while nothing is allocated makes vld_0=1 in the next cycle.
  - Indices do not wrap in any ordering sense; selection is always lowest-first.
- Reset asserted mid-operation: all entries return to free immediately (asynchronous), and outputs take their reset values.

Optional Feature:
- Macro VEC_CACHE_MSHR_ALLOC_CHK_EN.
- Defined:
  - err_double_free sets when any valid release targets a non-busy entry, or when two ports release the same index in one cycle.
  - It stays set until reset.
  - A simulation assertion fires on the same condition.
- Undefined: err_double_free is tied to 0 and the check logic is not built. Release semantics are otherwise identical.

Decomposition:
- vector_cache_pkg holds:
  - MSHR_ENTRY_NUM and MSHR_IDX_WIDTH constants (used as parameter defaults);
  - an mshr_idx_t typedef.
- Sub-module vec_cache_first2_sel: a combinational find-first-two-set-bits of an N-bit vector, producing two one-hot vectors, two indices and two valids. It is reused for slot selection.

Test Plan:
- Reset, then observe → vld_0=1/idx_0=0, vld_1=1/idx_1=1, free_cnt=16, full=0.
- Hold rdy_0=rdy_1=1 for 8 cycles → indices 0..15 granted in pairs; cycle 9 full=1, vld_0=vld_1=0, free_cnt=0.
- With pool full, release idx 5 on port 0 and idx 3 on port 1 in one cycle → next cycle idx_0=3, idx_1=5, free_cnt=2; both unavailable in the release cycle itself.
- 15 entries busy (only idx 9 free) → vld_0=1/idx_0=9, vld_1=0. Pulse rdy_1 alone → nothing allocated, free_cnt stays 1.
- Same cycle: allocate slot 0 (idx 2) and release idx 7 → next cycle busy[2]=1, busy[7]=0, free_cnt unchanged.
- With VEC_CACHE_MSHR_ALLOC_CHK_EN defined, release free idx 12 → err_double_free=1 next cycle and held, free_cnt unchanged. Without the macro → err_double_free stays 0.
